// File: rtl/alu_wide_sequencer.sv
// alu_wide_sequencer: runs 32-bit ADD/ADC/logic/shift requests as two
// 16-bit passes through an external ALU, then reports the result and flags.
`default_nettype none

module alu_wide_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [2:0]  i_req_op,
  input  logic [31:0] i_req_a,
  input  logic [31:0] i_req_b,
  output logic [15:0] o_alu_a,
  output logic [15:0] o_alu_b,
  output logic [4:0]  o_alu_fun_sel,
  output logic        o_alu_wf,
  input  logic [15:0] i_alu_out,
  input  logic [3:0]  i_alu_flags,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_result,
  output logic [3:0]  o_rsp_flags
);

  localparam logic [2:0] c_op_add = 3'b000;
  localparam logic [2:0] c_op_adc = 3'b001;
  localparam logic [2:0] c_op_and = 3'b010;
  localparam logic [2:0] c_op_or  = 3'b011;
  localparam logic [2:0] c_op_xor = 3'b100;
  localparam logic [2:0] c_op_lsl = 3'b101;
  localparam logic [2:0] c_op_lsr = 3'b110;

  localparam logic [4:0] c_fs_nop = 5'b10000;
  localparam logic [4:0] c_fs_add = 5'b10100;
  localparam logic [4:0] c_fs_adc = 5'b10101;
  localparam logic [4:0] c_fs_and = 5'b10111;
  localparam logic [4:0] c_fs_or  = 5'b11000;
  localparam logic [4:0] c_fs_xor = 5'b11001;
  localparam logic [4:0] c_fs_lsl = 5'b11011;
  localparam logic [4:0] c_fs_lsr = 5'b11100;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STEP1 = 3'd1,
    S_STEP2 = 3'd2,
    S_FLAGS = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t      r_state;
  logic [2:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [15:0] r_half;
  logic [31:0] r_res;
  logic [31:0] w_res;
  logic        w_unused_flags;

  assign w_unused_flags = ^{i_alu_flags[3], i_alu_flags[1]};

  function automatic logic [4:0] f_fun_sel(input logic [2:0] op, input logic second);
    case (op)
      c_op_add: f_fun_sel = second ? c_fs_adc : c_fs_add;
      c_op_adc: f_fun_sel = c_fs_adc;
      c_op_and: f_fun_sel = c_fs_and;
      c_op_or:  f_fun_sel = c_fs_or;
      c_op_xor: f_fun_sel = c_fs_xor;
      c_op_lsl: f_fun_sel = c_fs_lsl;
      c_op_lsr: f_fun_sel = c_fs_lsr;
      default:  f_fun_sel = c_fs_nop;
    endcase
  endfunction

  // LSR works high half first so the bit crossing the boundary moves downward.
  always_comb begin
    w_res = {i_alu_out, r_half};
    case (r_op)
      c_op_lsl: w_res[16] = i_alu_out[0] | r_a[15];
      c_op_lsr: begin
        w_res     = {r_half, i_alu_out};
        w_res[15] = i_alu_out[15] | r_a[16];
      end
      3'b111:   w_res = r_a;
      default:  w_res = {i_alu_out, r_half};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_op          <= 3'b000;
      r_a           <= 32'h0;
      r_b           <= 32'h0;
      r_half        <= 16'h0;
      r_res         <= 32'h0;
      o_req_ready   <= 1'b1;
      o_alu_a       <= 16'h0;
      o_alu_b       <= 16'h0;
      o_alu_fun_sel <= c_fs_nop;
      o_alu_wf      <= 1'b0;
      o_rsp_valid   <= 1'b0;
      o_rsp_result  <= 32'h0;
      o_rsp_flags   <= 4'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_op          <= i_req_op;
            r_a           <= i_req_a;
            r_b           <= i_req_b;
            o_req_ready   <= 1'b0;
            o_alu_fun_sel <= f_fun_sel(i_req_op, 1'b0);
            o_alu_wf      <= (i_req_op != 3'b111);
            o_alu_a       <= (i_req_op == c_op_lsr) ? i_req_a[31:16] : i_req_a[15:0];
            o_alu_b       <= (i_req_op == c_op_lsr) ? i_req_b[31:16] : i_req_b[15:0];
            r_state       <= S_STEP1;
          end
        end
        S_STEP1: begin
          r_half        <= i_alu_out;
          o_alu_fun_sel <= f_fun_sel(r_op, 1'b1);
          o_alu_a       <= (r_op == c_op_lsr) ? r_a[15:0] : r_a[31:16];
          o_alu_b       <= (r_op == c_op_lsr) ? r_b[15:0] : r_b[31:16];
          r_state       <= S_STEP2;
        end
        S_STEP2: begin
          r_res         <= w_res;
          o_alu_fun_sel <= c_fs_nop;
          o_alu_wf      <= 1'b0;
          o_alu_a       <= 16'h0;
          o_alu_b       <= 16'h0;
          r_state       <= S_FLAGS;
        end
        S_FLAGS: begin
          o_rsp_result <= r_res;
          o_rsp_flags  <= {(r_res == 32'h0), i_alu_flags[2], r_res[31], i_alu_flags[0]};
          o_rsp_valid  <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_wide_sequencer.sv
// tb_alu_wide_sequencer: drives alu_wide_sequencer against a behavioural
// 16-bit ALU and checks responses from a table of hand-computed vectors.
`default_nettype none

module tb_alu_wide_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [4:0]  alu_fs;
  logic        alu_wf;
  logic [3:0]  alu_flags = 4'h0;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
    int          hold;
  } vec_t;

  vec_t        tbl[14];
  logic [35:0] exp_q[$];

  alu_wide_sequencer dut (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_op(req_op),
    .i_req_a(req_a), .i_req_b(req_b),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_fun_sel(alu_fs), .o_alu_wf(alu_wf),
    .i_alu_out(alu_out), .i_alu_flags(alu_flags),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_result(rsp_result), .o_rsp_flags(rsp_flags)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: combinational result, flags {Z,C,N,O} written on WF.
  logic [16:0] m_s;
  logic [15:0] m_r;
  logic        m_c, m_o;
  always_comb begin
    m_s = 17'h0; m_r = 16'h0; m_c = 1'b0; m_o = 1'b0;
    case (alu_fs)
      5'b10100, 5'b10101: begin
        m_s = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0, (alu_fs == 5'b10101) & alu_flags[2]};
        m_r = m_s[15:0];
        m_c = m_s[16];
        m_o = (alu_a[15] == alu_b[15]) && (m_r[15] != alu_a[15]);
      end
      5'b10111: m_r = alu_a & alu_b;
      5'b11000: m_r = alu_a | alu_b;
      5'b11001: m_r = alu_a ^ alu_b;
      5'b11011: begin m_r = {alu_a[14:0], 1'b0}; m_c = alu_a[15]; end
      5'b11100: begin m_r = {1'b0, alu_a[15:1]}; m_c = alu_a[0]; end
      default:  m_r = 16'h0;
    endcase
  end
  assign alu_out = m_r;
  always @(posedge clk) if (alu_wf) alu_flags <= {(m_r == 16'h0), m_c, m_r[15], m_o};

  always @(negedge clk)
    if (!rst && alu_fs[4] !== 1'b1) begin
      n_err++;
      $display("FAIL fun_sel_range: got %b, required 1xxxx", alu_fs);
    end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
    end
  endtask

  function automatic logic [4:0] exp_fs(input logic [2:0] op, input bit second);
    case (op)
      3'b000:  return second ? 5'b10101 : 5'b10100;
      3'b001:  return 5'b10101;
      3'b010:  return 5'b10111;
      3'b011:  return 5'b11000;
      3'b100:  return 5'b11001;
      3'b101:  return 5'b11011;
      3'b110:  return 5'b11100;
      default: return 5'b10000;
    endcase
  endfunction

  task automatic run_req(input vec_t v);
    logic [4:0]  fs1, fs2;
    logic        wf1;
    logic [35:0] e;
    int          k;
    bit          got;
    fs1 = 5'h0; fs2 = 5'h0; wf1 = 1'b0;
    @(negedge clk);
    req_op = v.op; req_a = v.a; req_b = v.b; req_valid = 1'b1;
    rsp_ready = (v.hold == 0);
    check("req_ready_idle", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    exp_q.push_back({v.res, v.flg});
    #1 req_valid = 1'b0;
    k = 0; got = 1'b0;
    while (k < 12 && !got) begin
      @(negedge clk);
      k++;
      if (k == 1) begin fs1 = alu_fs; wf1 = alu_wf; end
      if (k == 2) fs2 = alu_fs;
      if (rsp_valid) got = 1'b1;
    end
    check("rsp_latency", k, 4);
    check("fun_sel_step1", {27'h0, fs1}, {27'h0, exp_fs(v.op, 1'b0)});
    check("fun_sel_step2", {27'h0, fs2}, {27'h0, exp_fs(v.op, 1'b1)});
    check("alu_wf_step1", {31'h0, wf1}, {31'h0, (v.op != 3'b111)});
    e = exp_q.pop_front();
    if (got) begin
      check("rsp_result", rsp_result, e[35:4]);
      check("rsp_flags", {28'h0, rsp_flags}, {28'h0, e[3:0]});
      check("req_ready_busy", {31'h0, req_ready}, 32'h0);
    end
    if (v.hold > 0) begin
      req_valid = 1'b1; req_op = 3'b000; req_a = 32'h1111_1111; req_b = 32'h2222_2222;
      repeat (v.hold) begin
        @(negedge clk);
        check("hold_valid", {31'h0, rsp_valid}, 32'h1);
        check("hold_result", rsp_result, e[35:4]);
        check("hold_flags", {28'h0, rsp_flags}, {28'h0, e[3:0]});
        check("hold_req_ready", {31'h0, req_ready}, 32'h0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    check("back_idle_valid", {31'h0, rsp_valid}, 32'h0);
    check("back_idle_ready", {31'h0, req_ready}, 32'h1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
    check({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
    check({tag, "_rsp_result"}, rsp_result, 32'h0);
    check({tag, "_rsp_flags"}, {28'h0, rsp_flags}, 32'h0);
    check({tag, "_alu_wf"}, {31'h0, alu_wf}, 32'h0);
    check({tag, "_alu_fs"}, {27'h0, alu_fs}, 32'h10);
    check({tag, "_alu_a"}, {16'h0, alu_a}, 32'h0);
    check({tag, "_alu_b"}, {16'h0, alu_b}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{3'b000, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 4'b0000, 0};
    tbl[1]  = '{3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1100, 0};
    tbl[2]  = '{3'b001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0003, 4'b0000, 0};
    tbl[3]  = '{3'b101, 32'h8000_8000, 32'h0000_0000, 32'h0001_0000, 4'b0100, 0};
    tbl[4]  = '{3'b110, 32'h0001_0001, 32'h0000_0000, 32'h0000_8000, 4'b0100, 0};
    tbl[5]  = '{3'b001, 32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0000, 4'b0011, 0};
    tbl[6]  = '{3'b010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'b0000, 0};
    tbl[7]  = '{3'b011, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 4'b0000, 0};
    tbl[8]  = '{3'b100, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 4'b1000, 5};
    tbl[9]  = '{3'b111, 32'hDEAD_BEEF, 32'h0000_0001, 32'hDEAD_BEEF, 4'b0010, 0};
    tbl[10] = '{3'b110, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 4'b1100, 0};
    tbl[11] = '{3'b111, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 4'b1100, 0};
    tbl[12] = '{3'b101, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFE, 4'b0110, 0};
    tbl[13] = '{3'b000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 4'b1101, 0};

    rst = 1'b1; req_valid = 1'b0; req_op = 3'b000; req_a = 32'h0; req_b = 32'h0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_req(tbl[i]);

    // Abort an ADD32 in STEP2 with an asynchronous reset.
    @(negedge clk);
    req_op = 3'b000; req_a = 32'h0000_FFFF; req_b = 32'h0000_0001; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_step2_fs", {27'h0, alu_fs}, 32'h15);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_rsp", {31'h0, rsp_valid}, 32'h0);
    run_req('{3'b000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 4'b0000, 0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
